// File: rtl/math24_pkg.sv
// Shared definitions for the 24-bit math coprocessor client: CSR map, CTRL/STATUS
// field positions, op codes and the client FSM state type.
package math24_pkg;

    localparam int DATA_W    = 24;
    localparam int CSR_AW    = 8;
    localparam int DRAIN_LEN = 3;

    localparam logic [CSR_AW-1:0] CSR_MATH_CTRL   = 8'h40;
    localparam logic [CSR_AW-1:0] CSR_MATH_STATUS = 8'h41;
    localparam logic [CSR_AW-1:0] CSR_MATH_OPA    = 8'h42;
    localparam logic [CSR_AW-1:0] CSR_MATH_OPB    = 8'h43;
    localparam logic [CSR_AW-1:0] CSR_MATH_OPC    = 8'h44;
    localparam logic [CSR_AW-1:0] CSR_MATH_RES0   = 8'h45;
    localparam logic [CSR_AW-1:0] CSR_MATH_RES1   = 8'h46;

    localparam int CTRL_START = 0;
    localparam int CTRL_OP_LO = 1;
    localparam int CTRL_OP_HI = 4;

    localparam int ST_READY = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_DIV0  = 2;

    localparam logic [3:0] OP_MULU    = 4'h0;
    localparam logic [3:0] OP_MULS    = 4'h1;
    localparam logic [3:0] OP_DIVU    = 4'h2;
    localparam logic [3:0] OP_DIVS    = 4'h3;
    localparam logic [3:0] OP_MODU    = 4'h4;
    localparam logic [3:0] OP_MODS    = 4'h5;
    localparam logic [3:0] OP_MINU    = 4'h6;
    localparam logic [3:0] OP_MINS    = 4'h7;
    localparam logic [3:0] OP_MAXU    = 4'h8;
    localparam logic [3:0] OP_MAXS    = 4'h9;
    localparam logic [3:0] OP_ADDS    = 4'hA;
    localparam logic [3:0] OP_SUBS    = 4'hB;
    localparam logic [3:0] OP_CLAMP_U = 4'hC;
    localparam logic [3:0] OP_CLAMP_S = 4'hD;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_OPA, S_WR_OPB, S_WR_OPC, S_WR_STAT, S_WR_CTRL,
        S_WAIT_ACK, S_WAIT_RDY, S_DRAIN, S_RD_RES0, S_RD_RES1, S_RSP
    } state_t;

    // CTRL word that launches an operation: op field plus START.
    function automatic logic [DATA_W-1:0] ctrl_word(input logic [3:0] op);
        return {19'd0, op, 1'b1};
    endfunction

endpackage

// File: rtl/math24_client.sv
// Command-side initiator: loads the MATH CSRs for one request, polls the coprocessor
// until it finishes (or times out) and returns the results as a single response.
module math24_client
    import math24_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_req_valid,
    output logic              ow_req_ready,
    input  logic [3:0]        iw_req_op,
    input  logic [DATA_W-1:0] iw_req_opa,
    input  logic [DATA_W-1:0] iw_req_opb,
    input  logic [DATA_W-1:0] iw_req_opc,
    output logic              ow_rsp_valid,
    input  logic              iw_rsp_ready,
    output logic [DATA_W-1:0] ow_rsp_res0,
    output logic [DATA_W-1:0] ow_rsp_res1,
    output logic              ow_rsp_div0,
    output logic              ow_rsp_timeout,
    output logic              ow_csr_wen,
    output logic [CSR_AW-1:0] ow_csr_waddr,
    output logic [DATA_W-1:0] ow_csr_wdata,
    input  logic              iw_csr_wgrant,
    output logic [CSR_AW-1:0] ow_csr_raddr,
    input  logic [DATA_W-1:0] iw_csr_rdata
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]    D_LAST = 2'(DRAIN_LEN - 1);

    state_t            state;
    logic [TW-1:0]     tcnt;
    logic [1:0]        dcnt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] opc_q;

    logic accept;
    assign accept = (state == S_IDLE) && iw_req_valid && ow_req_ready;

    // Operand capture: OPA goes straight to the write port, the rest wait their turn.
    always_ff @(posedge iw_clk) begin
        if (accept) begin
            op_q  <= iw_req_op;
            opb_q <= iw_req_opb;
            opc_q <= iw_req_opc;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state          <= S_IDLE;
            tcnt           <= '0;
            dcnt           <= '0;
            ow_req_ready   <= 1'b0;
            ow_rsp_valid   <= 1'b0;
            ow_rsp_res0    <= '0;
            ow_rsp_res1    <= '0;
            ow_rsp_div0    <= 1'b0;
            ow_rsp_timeout <= 1'b0;
            ow_csr_wen     <= 1'b0;
            ow_csr_waddr   <= '0;
            ow_csr_wdata   <= '0;
            ow_csr_raddr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ow_req_ready <= 1'b1;
                    if (accept) begin
                        ow_req_ready <= 1'b0;
                        ow_csr_wen   <= 1'b1;
                        ow_csr_waddr <= CSR_MATH_OPA;
                        ow_csr_wdata <= iw_req_opa;
                        state        <= S_WR_OPA;
                    end
                end
                S_WR_OPA: if (iw_csr_wgrant) begin
                    ow_csr_waddr <= CSR_MATH_OPB;
                    ow_csr_wdata <= opb_q;
                    state        <= S_WR_OPB;
                end
                S_WR_OPB: if (iw_csr_wgrant) begin
                    ow_csr_waddr <= CSR_MATH_OPC;
                    ow_csr_wdata <= opc_q;
                    state        <= S_WR_OPC;
                end
                S_WR_OPC: if (iw_csr_wgrant) begin
                    ow_csr_waddr <= CSR_MATH_STATUS;
                    ow_csr_wdata <= '0;
                    state        <= S_WR_STAT;
                end
                S_WR_STAT: if (iw_csr_wgrant) begin
                    ow_csr_waddr <= CSR_MATH_CTRL;
                    ow_csr_wdata <= ctrl_word(op_q);
                    state        <= S_WR_CTRL;
                end
                S_WR_CTRL: if (iw_csr_wgrant) begin
                    ow_csr_wen   <= 1'b0;
                    ow_csr_waddr <= '0;
                    ow_csr_wdata <= '0;
                    ow_csr_raddr <= CSR_MATH_CTRL;
                    tcnt         <= '0;
                    state        <= S_WAIT_ACK;
                end
                // Coprocessor acknowledges by clearing START.
                S_WAIT_ACK: begin
                    if (!iw_csr_rdata[CTRL_START]) begin
                        ow_csr_raddr <= CSR_MATH_STATUS;
                        tcnt         <= '0;
                        state        <= S_WAIT_RDY;
                    end else if (tcnt == T_LAST) begin
                        ow_csr_raddr   <= '0;
                        ow_rsp_valid   <= 1'b1;
                        ow_rsp_res0    <= '0;
                        ow_rsp_res1    <= '0;
                        ow_rsp_div0    <= 1'b0;
                        ow_rsp_timeout <= 1'b1;
                        state          <= S_RSP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (iw_csr_rdata[ST_READY] && !iw_csr_rdata[ST_BUSY]) begin
                        if (iw_csr_rdata[ST_DIV0]) begin
                            ow_csr_raddr <= '0;
                            dcnt         <= '0;
                            state        <= S_DRAIN;
                        end else begin
                            ow_csr_raddr <= CSR_MATH_RES0;
                            state        <= S_RD_RES0;
                        end
                    end else if (tcnt == T_LAST) begin
                        ow_csr_raddr   <= '0;
                        ow_rsp_valid   <= 1'b1;
                        ow_rsp_res0    <= '0;
                        ow_rsp_res1    <= '0;
                        ow_rsp_div0    <= 1'b0;
                        ow_rsp_timeout <= 1'b1;
                        state          <= S_RSP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                // Let the coprocessor finish its writeback before releasing the bus.
                S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == D_LAST) begin
                        ow_rsp_valid   <= 1'b1;
                        ow_rsp_res0    <= '0;
                        ow_rsp_res1    <= '0;
                        ow_rsp_div0    <= 1'b1;
                        ow_rsp_timeout <= 1'b0;
                        state          <= S_RSP;
                    end
                end
                S_RD_RES0: begin
                    ow_rsp_res0  <= iw_csr_rdata;
                    ow_csr_raddr <= CSR_MATH_RES1;
                    state        <= S_RD_RES1;
                end
                S_RD_RES1: begin
                    ow_rsp_res1    <= iw_csr_rdata;
                    ow_csr_raddr   <= '0;
                    ow_rsp_valid   <= 1'b1;
                    ow_rsp_div0    <= 1'b0;
                    ow_rsp_timeout <= 1'b0;
                    state          <= S_RSP;
                end
                S_RSP: if (iw_rsp_ready) begin
                    ow_rsp_valid <= 1'b0;
                    ow_req_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
